image_rom_arbiter: RTL and testbench
====================================

// Module: image_rom_arbiter
// PURPOSE
//  Shares the single-port 640x480x12b background image ROM between two requesters:
//  port 0 = VGA pixel fetch (real-time, priority), port 1 = secondary reader
//  (game-over / snapshot renderer). Fully pipelined, one ROM access per cycle.
//  Anti-starvation counter guarantees port 1 a slot. Sits between the display
//  pipeline and image_rom, and drives rom_addr directly.
// PARAMETERS
//  AW          19      address width (ROM_DEPTH fits in 2^19)
//  DW          12      pixel width, RGB444
//  ROM_DEPTH   307200  valid addresses 0..307199
//  ROM_LATENCY 0       cycles from rom_addr change to valid rom_data (0 = combinational ROM)
//  MAX_WAIT    4       cycles port 1 may wait before it pre-empts port 0 (>=1)
// PORTS
//  clk        in   1   system clock
//  rst_n      in   1   asynchronous active-low reset
//  req0_i     in   1   port 0 read request
//  addr0_i    in   AW  port 0 address
//  gnt0_o     out  1   port 0 accepted this cycle (combinational)
//  rvalid0_o  out  1   port 0 read data valid, one-cycle pulse
//  rdata0_o   out  DW  port 0 read data
//  req1_i / addr1_i / gnt1_o / rvalid1_o / rdata1_o   same set for port 1
//  rom_addr_o out  AW  address to image_rom (registered)
//  rom_data_i in   DW  data from image_rom
// BEHAVIOUR
//  - Reset: rom_addr_o=0, rvalid*=0, rdata*=0, wait_cnt=0, all in-flight tags cleared.
//  - Transfer on port n when req_n && gnt_n in the same cycle. At most one grant per cycle.
//  - Grant rule, evaluated each cycle:
//      req1 && wait_cnt==MAX_WAIT -> gnt1; else req0 -> gnt0; else req1 -> gnt1; else none.
//  - wait_cnt: +1 when req1 && !gnt1, saturating at MAX_WAIT; cleared to 0 on gnt1 or !req1.
//  - Issue stage (grant cycle t): rom_addr_o <= granted addr at end of t; tag {valid,port,oor}
//    registered alongside. No grant -> rom_addr_o holds, tag valid=0.
//  - Out-of-range addr (>= ROM_DEPTH): still granted, oor=1, rom_addr_o holds its
//    previous value; returned rdata = 0.
//  - Tag delayed ROM_LATENCY more cycles; at the end, rdata_n <= oor ? 0 : rom_data_i and
//    rvalid_n pulses for the tagged port. Grant-to-rvalid latency = ROM_LATENCY+2 cycles.
//    Responses return in grant order. rdata holds its value between pulses.
//  - rvalid0 and rvalid1 are never high in the same cycle.
//  - Requester may drop req without a grant; no state is kept for it except wait_cnt clear.
//  - Reset mid-operation: in-flight accesses discarded, no rvalid after rst_n deasserts
//    until a new grant has gone through the full latency.
// STRUCTURE
//  - Shared package snake_pkg: H_RES=640, V_RES=480, ROM_DEPTH, AW, DW, rom_tag_t
//    {valid, port, oor}.
//  - Sub-module rom_tag_pipe: parameterised ROM_LATENCY-deep shift register of
//    rom_tag_t, async clear; depth 0 = wire-through.
//  - Arbiter + wait counter + issue/response registers live in this module.
// TESTING (image_rom model with known pattern, ROM_LATENCY=0 unless stated)
//  1. req0 only, addr0 = 0,1,2,3 back-to-back -> gnt0 every cycle; rvalid0 on t+2..t+5
//     with ROM[0..3]; rvalid1 never high.
//  2. req0 and req1 held high, MAX_WAIT=4 -> grant pattern 0,0,0,0,1 repeating; wait_cnt
//     reaches 4 then clears; responses arrive in grant order.
//  3. req1 only, addr1=640 -> gnt1 same cycle; rvalid1 at t+2, rdata1 = ROM[640].
//  4. addr0 = 307200 then 19'h7FFFF -> both granted, rdata0 = 12'h000, rom_addr_o unchanged.
//  5. Two accesses in flight, pulse rst_n low -> all outputs 0 immediately; no rvalid
//     after release until a new request completes.
//  6. ROM_LATENCY=1, addr1=307199 -> rvalid1 at t+3, rdata1 = ROM[307199].

Source files
------------

// File: rtl/snake_pkg.sv
// Shared constants and types for the background image ROM path.
// The ROM holds one 12-bit RGB444 pixel per screen position.
package snake_pkg;

    localparam int H_RES     = 640;
    localparam int V_RES     = 480;
    localparam int ROM_DEPTH = H_RES * V_RES;
    localparam int AW        = 19;
    localparam int DW        = 12;
    localparam int MAX_WAIT  = 4;

    // One entry per ROM slot: whether it carries a read, for which port,
    // and whether the address was outside the image.
    typedef struct packed {
        logic valid;
        logic port;
        logic oor;
    } rom_tag_t;

endpackage

// File: rtl/rom_tag_pipe.sv
// Delay line for ROM access tags, matching the ROM read latency.
// A depth of zero makes the tag pass straight through.
module rom_tag_pipe
    import snake_pkg::*;
#(
    parameter int DEPTH = 0
) (
    input  logic     i_clk,
    input  logic     i_rst_n,
    input  rom_tag_t i_tag,
    output rom_tag_t o_tag
);

    generate
        if (DEPTH == 0) begin : g_wire
            logic w_unused_clk;
            assign w_unused_clk = i_clk ^ i_rst_n;
            assign o_tag        = i_tag;
        end else begin : g_pipe
            rom_tag_t r_stage [DEPTH];

            // shift the tag one stage per cycle; reset drops everything in flight
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        r_stage[i] <= '0;
                    end
                end else begin
                    r_stage[0] <= i_tag;
                    for (int i = 1; i < DEPTH; i++) begin
                        r_stage[i] <= r_stage[i-1];
                    end
                end
            end

            assign o_tag = r_stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/image_rom_arbiter.sv
// Two-port arbiter in front of the single-port background image ROM.
// Port 0 (VGA fetch) has priority; port 1 is guaranteed a slot after MAX_WAIT cycles.
module image_rom_arbiter #(
    parameter int AW          = snake_pkg::AW,
    parameter int DW          = snake_pkg::DW,
    parameter int ROM_DEPTH   = snake_pkg::ROM_DEPTH,
    parameter int ROM_LATENCY = 0,
    parameter int MAX_WAIT    = snake_pkg::MAX_WAIT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0_i,
    input  logic [AW-1:0] addr0_i,
    output logic          gnt0_o,
    output logic          rvalid0_o,
    output logic [DW-1:0] rdata0_o,
    input  logic          req1_i,
    input  logic [AW-1:0] addr1_i,
    output logic          gnt1_o,
    output logic          rvalid1_o,
    output logic [DW-1:0] rdata1_o,
    output logic [AW-1:0] rom_addr_o,
    input  logic [DW-1:0] rom_data_i
);

    import snake_pkg::*;

    localparam int             WCW      = $clog2(MAX_WAIT + 1);
    localparam logic [WCW-1:0] WAIT_MAX = WCW'(MAX_WAIT);

    logic           w_gnt0;
    logic           w_gnt1;
    logic           w_grant;
    logic [AW-1:0]  w_sel_addr;
    logic           w_sel_oor;
    logic [WCW-1:0] r_wait_cnt;
    logic [AW-1:0]  r_rom_addr;
    rom_tag_t       r_issue_tag;
    rom_tag_t       w_resp_tag;
    logic           r_rvalid0;
    logic           r_rvalid1;
    logic [DW-1:0]  r_rdata0;
    logic [DW-1:0]  r_rdata1;

    // grant decision: a starved port 1 overrides the normal port-0 priority
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (req1_i && (r_wait_cnt == WAIT_MAX)) begin
            w_gnt1 = 1'b1;
        end else if (req0_i) begin
            w_gnt0 = 1'b1;
        end else if (req1_i) begin
            w_gnt1 = 1'b1;
        end else begin
            w_gnt0 = 1'b0;
            w_gnt1 = 1'b0;
        end
    end

    assign w_grant    = w_gnt0 | w_gnt1;
    assign w_sel_addr = w_gnt1 ? addr1_i : addr0_i;
    assign w_sel_oor  = (32'(w_sel_addr) >= 32'(ROM_DEPTH));

    // count how long port 1 has been passed over; a dropped request forgets its history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= '0;
        end else if (req1_i && !w_gnt1) begin
            if (r_wait_cnt != WAIT_MAX) begin
                r_wait_cnt <= r_wait_cnt + WCW'(1);
            end else begin
                r_wait_cnt <= r_wait_cnt;
            end
        end else begin
            r_wait_cnt <= '0;
        end
    end

    // issue stage: out-of-range reads are tagged but leave the ROM address untouched
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rom_addr  <= '0;
            r_issue_tag <= '0;
        end else begin
            r_issue_tag.valid <= w_grant;
            r_issue_tag.port  <= w_gnt1;
            r_issue_tag.oor   <= w_grant & w_sel_oor;
            if (w_grant && !w_sel_oor) begin
                r_rom_addr <= w_sel_addr;
            end else begin
                r_rom_addr <= r_rom_addr;
            end
        end
    end

    rom_tag_pipe #(
        .DEPTH (ROM_LATENCY)
    ) u_tag_pipe (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_tag   (r_issue_tag),
        .o_tag   (w_resp_tag)
    );

    // response stage: steer ROM data to the tagged port, hold rdata between pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            r_rdata0  <= '0;
            r_rdata1  <= '0;
        end else if (w_resp_tag.valid) begin
            r_rvalid0 <= ~w_resp_tag.port;
            r_rvalid1 <= w_resp_tag.port;
            if (w_resp_tag.port) begin
                r_rdata0 <= r_rdata0;
                r_rdata1 <= w_resp_tag.oor ? '0 : rom_data_i;
            end else begin
                r_rdata0 <= w_resp_tag.oor ? '0 : rom_data_i;
                r_rdata1 <= r_rdata1;
            end
        end else begin
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            r_rdata0  <= r_rdata0;
            r_rdata1  <= r_rdata1;
        end
    end

    assign gnt0_o     = w_gnt0;
    assign gnt1_o     = w_gnt1;
    assign rom_addr_o = r_rom_addr;
    assign rvalid0_o  = r_rvalid0;
    assign rvalid1_o  = r_rvalid1;
    assign rdata0_o   = r_rdata0;
    assign rdata1_o   = r_rdata1;

endmodule

// File: tb/tb_image_rom_arbiter.sv
// Directed bench for image_rom_arbiter: a zero-latency instance driven cycle by cycle
// against a response scoreboard, plus a one-cycle-latency instance for the deep-pipe case.
module tb_image_rom_arbiter;

    localparam int AW = 19;
    localparam int DW = 12;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0, req1, gnt0, gnt1, rv0, rv1;
    logic [AW-1:0] addr0, addr1, rom_addr;
    logic [DW-1:0] rd0, rd1, rom_data;

    logic          l_req0, l_req1, l_gnt0, l_gnt1, l_rv0, l_rv1;
    logic [AW-1:0] l_addr0, l_addr1, l_rom_addr;
    logic [DW-1:0] l_rd0, l_rd1, l_rom_data;

    typedef struct {
        int            due;
        bit            port;
        logic [DW-1:0] data;
    } resp_t;

    resp_t         q[$];
    int            n_vec  = 0;
    int            n_miss = 0;
    int            cyc    = 0;
    logic [DW-1:0] exp_d0, exp_d1;
    logic [AW-1:0] exp_ra;

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] rom_pat(input logic [AW-1:0] a);
        return a[11:0] ^ {5'd0, a[18:12]} ^ 12'hA5C;
    endfunction

    function automatic bit is_oor(input logic [AW-1:0] a);
        return a >= 19'd307200;
    endfunction

    assign rom_data = rom_pat(rom_addr);

    always @(posedge clk) l_rom_data <= rom_pat(l_rom_addr);

    image_rom_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0_i(req0), .addr0_i(addr0), .gnt0_o(gnt0), .rvalid0_o(rv0), .rdata0_o(rd0),
        .req1_i(req1), .addr1_i(addr1), .gnt1_o(gnt1), .rvalid1_o(rv1), .rdata1_o(rd1),
        .rom_addr_o(rom_addr), .rom_data_i(rom_data)
    );

    image_rom_arbiter #(.ROM_LATENCY(1)) dut_lat1 (
        .clk(clk), .rst_n(rst_n),
        .req0_i(l_req0), .addr0_i(l_addr0), .gnt0_o(l_gnt0), .rvalid0_o(l_rv0), .rdata0_o(l_rd0),
        .req1_i(l_req1), .addr1_i(l_addr1), .gnt1_o(l_gnt1), .rvalid1_o(l_rv1), .rdata1_o(l_rd1),
        .rom_addr_o(l_rom_addr), .rom_data_i(l_rom_data)
    );

    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    // advance one clock and check the registered outputs against the scoreboard
    task automatic tick();
        resp_t e;
        bit    ev0, ev1;
        @(posedge clk);
        #1;
        cyc++;
        ev0 = 1'b0;
        ev1 = 1'b0;
        if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            if (e.port) begin
                ev1    = 1'b1;
                exp_d1 = e.data;
            end else begin
                ev0    = 1'b1;
                exp_d0 = e.data;
            end
        end
        check_vec("rvalid0", 32'(rv0), 32'(ev0));
        check_vec("rvalid1", 32'(rv1), 32'(ev1));
        check_vec("rdata0", 32'(rd0), 32'(exp_d0));
        check_vec("rdata1", 32'(rd1), 32'(exp_d1));
        check_vec("rom_addr", 32'(rom_addr), 32'(exp_ra));
    endtask

    // drive one cycle of requests with the hand-derived grant outcome
    task automatic apply(input bit r0, input logic [AW-1:0] a0,
                         input bit r1, input logic [AW-1:0] a1,
                         input bit e0, input bit e1);
        req0  = r0;
        addr0 = a0;
        req1  = r1;
        addr1 = a1;
        #1;
        check_vec("gnt0", 32'(gnt0), 32'(e0));
        check_vec("gnt1", 32'(gnt1), 32'(e1));
        if (e0) begin
            q.push_back('{cyc + 2, 1'b0, is_oor(a0) ? 12'h000 : rom_pat(a0)});
            if (!is_oor(a0)) exp_ra = a0;
        end
        if (e1) begin
            q.push_back('{cyc + 2, 1'b1, is_oor(a1) ? 12'h000 : rom_pat(a1)});
            if (!is_oor(a1)) exp_ra = a1;
        end
        tick();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) apply(1'b0, 19'd0, 1'b0, 19'd0, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n  = 1'b0;
        req0   = 1'b0; req1 = 1'b0; addr0 = '0; addr1 = '0;
        l_req0 = 1'b0; l_req1 = 1'b0; l_addr0 = '0; l_addr1 = '0;
        exp_d0 = '0; exp_d1 = '0; exp_ra = '0;
        #1;
        check_vec("rst_rom_addr", 32'(rom_addr), 32'd0);
        check_vec("rst_rvalid0", 32'(rv0), 32'd0);
        check_vec("rst_rvalid1", 32'(rv1), 32'd0);
        check_vec("rst_rdata0", 32'(rd0), 32'd0);
        check_vec("rst_rdata1", 32'(rd1), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // port 0 streaming, back-to-back
        for (int i = 0; i < 4; i++) apply(1'b1, 19'(i), 1'b0, 19'd0, 1'b1, 1'b0);
        idle(2);

        // both ports contending: port 1 wins every fifth slot
        for (int i = 0; i < 10; i++)
            apply(1'b1, 19'(100 + i), 1'b1, 19'(2000 + i), (i % 5) != 4, (i % 5) == 4);
        idle(2);

        // dropping req1 clears the starvation count
        for (int i = 0; i < 3; i++) apply(1'b1, 19'(300 + i), 1'b1, 19'd400, 1'b1, 1'b0);
        apply(1'b1, 19'd303, 1'b0, 19'd0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) apply(1'b1, 19'(310 + i), 1'b1, 19'd410, 1'b1, 1'b0);
        apply(1'b1, 19'd314, 1'b1, 19'd410, 1'b0, 1'b1);
        idle(2);

        // port 1 alone, first pixel of the second row
        apply(1'b0, 19'd0, 1'b1, 19'd640, 1'b0, 1'b1);
        idle(2);

        // out-of-range reads: granted, zero data, ROM address untouched
        apply(1'b1, 19'd307200, 1'b0, 19'd0, 1'b1, 1'b0);
        apply(1'b1, 19'h7FFFF, 1'b0, 19'd0, 1'b1, 1'b0);
        idle(2);

        // reset with one access issued and another being granted
        apply(1'b1, 19'd10, 1'b0, 19'd0, 1'b1, 1'b0);
        req0  = 1'b0;
        req1  = 1'b1;
        addr1 = 19'd20;
        #1;
        check_vec("gnt1_pre_rst", 32'(gnt1), 32'd1);
        rst_n = 1'b0;
        req1  = 1'b0;
        #1;
        check_vec("midrst_rom_addr", 32'(rom_addr), 32'd0);
        check_vec("midrst_rvalid0", 32'(rv0), 32'd0);
        check_vec("midrst_rvalid1", 32'(rv1), 32'd0);
        check_vec("midrst_rdata0", 32'(rd0), 32'd0);
        check_vec("midrst_rdata1", 32'(rd1), 32'd0);
        q.delete();
        exp_d0 = '0;
        exp_d1 = '0;
        exp_ra = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(3);
        apply(1'b1, 19'd5, 1'b0, 19'd0, 1'b1, 1'b0);
        idle(2);

        check_vec("drained", 32'(q.size()), 32'd0);

        // one-cycle ROM latency: last pixel, response three cycles after grant
        l_req1  = 1'b1;
        l_addr1 = 19'd307199;
        #1;
        check_vec("lat1_gnt1", 32'(l_gnt1), 32'd1);
        @(posedge clk);
        #1;
        l_req1 = 1'b0;
        check_vec("lat1_rom_addr", 32'(l_rom_addr), 32'd307199);
        check_vec("lat1_rvalid1_t1", 32'(l_rv1), 32'd0);
        @(posedge clk);
        #1;
        check_vec("lat1_rvalid1_t2", 32'(l_rv1), 32'd0);
        @(posedge clk);
        #1;
        check_vec("lat1_rvalid1_t3", 32'(l_rv1), 32'd1);
        check_vec("lat1_rdata1", 32'(l_rd1), 32'(rom_pat(19'd307199)));
        check_vec("lat1_rvalid0", 32'(l_rv0), 32'd0);
        @(posedge clk);
        #1;
        check_vec("lat1_rvalid1_t4", 32'(l_rv1), 32'd0);
        check_vec("lat1_rdata1_hold", 32'(l_rd1), 32'(rom_pat(19'd307199)));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
